tx_word_emitter: RTL and testbench



---
 rtl/tx_word_emitter.sv | 115 +++++++++++
 tb/tb_tx_word_emitter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_word_emitter.sv
// Change-detect word link transmitter: emits {toggle, payload} words so that
// consecutive words always differ. Optional GAP state under TX_WORD_EMITTER_GAP_EN.
module tx_word_emitter #(
  parameter int PAY_W = 11,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [PAY_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PAY_W:0]   data_out,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] sent,
  output logic             done
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SEND = 4'b0010,
`ifdef TX_WORD_EMITTER_GAP_EN
    ST_GAP  = 4'b0100,
`endif
    ST_DONE = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [PAY_W:0]   data_q, data_d;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] sent_inc;

  assign in_ready = (state_q == ST_SEND);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    toggle_d = toggle_q;
    sent_d   = sent_q;
    target_d = target_q;
    done_d   = 1'b0;
    sent_inc = sent_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        data_d   = '0;
        toggle_d = 1'b0;
        sent_d   = '0;
        if (start && (num_words != '0)) begin
          target_d = num_words;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (in_valid && in_ready) begin
          // Inverted toggle leads, so the first word of a burst is never zero.
          data_d   = {~toggle_q, in_data};
          toggle_d = ~toggle_q;
          sent_d   = sent_inc;
          if (sent_inc == target_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
`ifdef TX_WORD_EMITTER_GAP_EN
            state_d = ST_GAP;
`else
            state_d = ST_SEND;
`endif
          end
        end
      end
`ifdef TX_WORD_EMITTER_GAP_EN
      ST_GAP: begin
        state_d = ST_SEND;
      end
`endif
      ST_DONE: begin
        state_d  = ST_IDLE;
        data_d   = '0;
        toggle_d = 1'b0;
        sent_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      toggle_q <= 1'b0;
      sent_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      toggle_q <= toggle_d;
      sent_q   <= sent_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign data_out = data_q;
  assign state    = state_q;
  assign sent     = sent_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tx_word_emitter.sv
// Self-checking bench for tx_word_emitter: spec-level model compared every cycle,
// plus directed literal expectations. Honours TX_WORD_EMITTER_GAP_EN.
module tb_tx_word_emitter;

`ifdef TX_WORD_EMITTER_GAP_EN
  localparam bit GAP = 1'b1;
  localparam int NA  = 7;
  localparam logic [3:0]  A_ST   [7] = '{4'h2, 4'h4, 4'h2, 4'h4, 4'h2, 4'h8, 4'h1};
  localparam logic [11:0] A_DO   [7] = '{12'h000, 12'h805, 12'h805, 12'h005, 12'h005, 12'h805, 12'h000};
  localparam int          A_SENT [7] = '{0, 1, 1, 2, 2, 3, 0};
`else
  localparam bit GAP = 1'b0;
  localparam int NA  = 5;
  localparam logic [3:0]  A_ST   [5] = '{4'h2, 4'h2, 4'h2, 4'h8, 4'h1};
  localparam logic [11:0] A_DO   [5] = '{12'h000, 12'h805, 12'h005, 12'h805, 12'h000};
  localparam int          A_SENT [5] = '{0, 1, 2, 3, 0};
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  num_words;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] data_out;
  logic [3:0]  state;
  logic [4:0]  sent;
  logic        done;

  int checks = 0;
  int errors = 0;

  tx_word_emitter #(.PAY_W(11), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .state(state), .sent(sent), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: word k of a burst carries bit11 = (k odd); bursts end after target words.
  int          m_st;
  int          m_sent;
  int          m_target;
  logic [11:0] m_data;
  bit          m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 1; m_sent = 0; m_target = 0; m_data = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_st == 1) begin
        m_sent = 0; m_data = '0;
        if (start && num_words != 0) begin
          m_target = int'(num_words);
          m_st = 2;
        end
      end else if (m_st == 2) begin
        if (in_valid) begin
          m_sent = m_sent + 1;
          m_data = {(m_sent % 2 == 1), in_data};
          if (m_sent == m_target) begin
            m_st = 8; m_done = 1'b1;
          end else begin
            m_st = GAP ? 4 : 2;
          end
        end
      end else if (m_st == 4) begin
        m_st = 2;
      end else begin
        m_st = 1; m_sent = 0; m_data = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_state", 32'(state), 32'(m_st));
      chk("model_data_out", 32'(data_out), 32'(m_data));
      chk("model_sent", 32'(sent), 32'(m_sent));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_in_ready", 32'(in_ready), 32'(m_st == 2));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int          hs;
  int          cd;
  logic [11:0] cd_prev;
  bit          seen_done;

  initial begin
    reset = 1'b1; start = 1'b0; num_words = '0; in_data = '0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'h1);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;

    // Burst of 3 with constant payload 0x005
    @(negedge clk);
    start = 1'b1; num_words = 5'd3; in_valid = 1'b1; in_data = 11'h005;
    for (int i = 0; i < NA; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("b3_state", 32'(state), 32'(A_ST[i]));
      chk("b3_data_out", 32'(data_out), 32'(A_DO[i]));
      chk("b3_sent", 32'(sent), 32'(A_SENT[i]));
      chk("b3_done", 32'(done), 32'(A_ST[i] == 4'h8));
      chk("b3_in_ready", 32'(in_ready), 32'(A_ST[i] == 4'h2));
    end
    in_valid = 1'b0;

    // Zero-length start is ignored
    @(negedge clk);
    start = 1'b1; num_words = 5'd0;
    @(negedge clk);
    chk("zero_len_state", 32'(state), 32'h1);
    chk("zero_len_in_ready", 32'(in_ready), 32'h0);
    num_words = 5'd2;
    @(negedge clk);
    start = 1'b0;
    chk("stall_enter_send", 32'(state), 32'h2);
    in_valid = 1'b1; in_data = 11'h123;
    @(negedge clk);
    chk("stall_first_word", 32'(data_out), 32'h923);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_state", 32'(state), 32'h2);
      chk("stall_data_out", 32'(data_out), 32'h923);
      chk("stall_sent", 32'(sent), 32'h1);
    end
    in_valid = 1'b1; in_data = 11'h0AA; start = 1'b1; num_words = 5'd7;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("stall_end_state", 32'(state), 32'h8);
    chk("stall_end_data", 32'(data_out), 32'h0AA);
    chk("stall_end_sent", 32'(sent), 32'h2);
    chk("stall_end_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("stall_back_idle", 32'(state), 32'h1);

    // Asynchronous reset in the middle of a burst
    start = 1'b1; num_words = 5'd4; in_valid = 1'b1; in_data = 11'h3F0;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'h1);
    chk("async_rst_data", 32'(data_out), 32'h0);
    chk("async_rst_sent", 32'(sent), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(state), 32'h1);

    // Full-length burst of 31 with random payload and random stalls
    hs = 0; cd = 0; cd_prev = '0; seen_done = 1'b0;
    start = 1'b1; num_words = 5'd31;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (state == 4'h1) cd = 0;
      else if (data_out != cd_prev) cd++;
      cd_prev = data_out;
      if (state == 4'h8) begin
        seen_done = 1'b1;
        chk("b31_sent", 32'(sent), 32'd31);
        chk("b31_done", 32'(done), 32'h1);
        chk("b31_handshakes", 32'(hs), 32'd31);
        chk("b31_change_count", 32'(cd), 32'd31);
        chk("b31_last_toggle", 32'(data_out[11]), 32'h1);
        in_valid = 1'b0;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 11'($urandom);
        if (in_valid && in_ready) hs++;
      end
    end
    chk("b31_done_seen", 32'(seen_done), 32'h1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
